// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchronizer, counter-based debounce FSM and
// press / release / long-press event generation, all outputs registered.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES   = 32'd160000,
  parameter int unsigned LONG_PRESS_CYCLES = 32'd16000000,
  parameter bit          ACTIVE_LOW_IN     = 1'b1
) (
  input  logic clk,
  input  logic in_rst,
  input  logic btn_in,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic long_held
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES + 32'd1);

  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [DW-1:0] DCNT_ONE  = DW'(32'd1);
  localparam logic [DW-1:0] DCNT_ZERO = DW'(32'd0);
  localparam logic [HW-1:0] HCNT_LAST = HW'(LONG_PRESS_CYCLES - 32'd1);
  localparam logic [HW-1:0] HCNT_ONE  = HW'(32'd1);
  localparam logic [HW-1:0] HCNT_ZERO = HW'(32'd0);

  // Pin level of a released button; the synchronizer idles here out of reset.
  localparam logic PIN_IDLE = ACTIVE_LOW_IN;

  typedef enum logic [1:0] {
    ST_RELEASED   = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_PRESSED    = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_t;

  logic          sync1_r, sync2_r;
  logic          lvl_s;
  state_t        state_r, state_nxt_s;
  logic [DW-1:0] dcnt_r, dcnt_nxt_s;
  logic [HW-1:0] hcnt_r, hcnt_nxt_s;
  logic          btn_state_r, btn_state_nxt_s;
  logic          press_r, press_nxt_s;
  logic          release_r, release_nxt_s;
  logic          long_r, long_nxt_s;
  logic          long_held_r, long_held_nxt_s;

  // Two-flop synchronizer on the raw pin.
  always_ff @(posedge clk or negedge in_rst) begin
    if (!in_rst) begin
      sync1_r <= PIN_IDLE;
      sync2_r <= PIN_IDLE;
    end else begin
      sync1_r <= btn_in;
      sync2_r <= sync1_r;
    end
  end

  assign lvl_s = sync2_r ^ ACTIVE_LOW_IN;

  // Next-state, counter and event decode for the debounce FSM.
  always_comb begin
    state_nxt_s     = state_r;
    dcnt_nxt_s      = dcnt_r;
    hcnt_nxt_s      = hcnt_r;
    long_held_nxt_s = long_held_r;
    press_nxt_s     = 1'b0;
    release_nxt_s   = 1'b0;
    long_nxt_s      = 1'b0;
    case (state_r)
      ST_RELEASED: begin
        if (lvl_s) begin
          state_nxt_s = ST_PRESS_DB;
          dcnt_nxt_s  = DCNT_ZERO;
        end else begin
          state_nxt_s = ST_RELEASED;
        end
      end
      ST_PRESS_DB: begin
        if (!lvl_s) begin
          state_nxt_s = ST_RELEASED;
        end else if (dcnt_r == DCNT_LAST) begin
          state_nxt_s = ST_PRESSED;
          press_nxt_s = 1'b1;
          hcnt_nxt_s  = HCNT_ZERO;
        end else begin
          dcnt_nxt_s = dcnt_r + DCNT_ONE;
        end
      end
      ST_PRESSED: begin
        // Saturating hold count; long_held keeps the strobe to once per press.
        if (hcnt_r != HCNT_LAST) begin
          hcnt_nxt_s = hcnt_r + HCNT_ONE;
        end else begin
          hcnt_nxt_s = hcnt_r;
        end
        if ((hcnt_nxt_s == HCNT_LAST) && !long_held_r) begin
          long_nxt_s      = 1'b1;
          long_held_nxt_s = 1'b1;
        end else begin
          long_nxt_s = 1'b0;
        end
        if (!lvl_s) begin
          state_nxt_s = ST_RELEASE_DB;
          dcnt_nxt_s  = DCNT_ZERO;
        end else begin
          state_nxt_s = ST_PRESSED;
        end
      end
      ST_RELEASE_DB: begin
        if (lvl_s) begin
          state_nxt_s = ST_PRESSED;
        end else if (dcnt_r == DCNT_LAST) begin
          state_nxt_s     = ST_RELEASED;
          release_nxt_s   = 1'b1;
          long_held_nxt_s = 1'b0;
          hcnt_nxt_s      = HCNT_ZERO;
        end else begin
          dcnt_nxt_s = dcnt_r + DCNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_RELEASED;
      end
    endcase
    btn_state_nxt_s = (state_nxt_s == ST_PRESSED) || (state_nxt_s == ST_RELEASE_DB);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge in_rst) begin
    if (!in_rst) begin
      state_r     <= ST_RELEASED;
      dcnt_r      <= DCNT_ZERO;
      hcnt_r      <= HCNT_ZERO;
      btn_state_r <= 1'b0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      long_r      <= 1'b0;
      long_held_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      dcnt_r      <= dcnt_nxt_s;
      hcnt_r      <= hcnt_nxt_s;
      btn_state_r <= btn_state_nxt_s;
      press_r     <= press_nxt_s;
      release_r   <= release_nxt_s;
      long_r      <= long_nxt_s;
      long_held_r <= long_held_nxt_s;
    end
  end

  assign btn_state        = btn_state_r;
  assign press_pulse      = press_r;
  assign release_pulse    = release_r;
  assign long_press_pulse = long_r;
  assign long_held        = long_held_r;

endmodule
